// File: rtl/vram_write_arbiter.sv
// Round-robin write arbiter for the three tile RAMs' port A, with an optional vblank-only
// write window and a per-frame write budget.
module vram_write_arbiter #(
  parameter bit          VBLANK_ONLY = 1'b1,
  parameter int unsigned WR_BUDGET   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        vblank,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_target,
  input  logic [11:0] req0_addr,
  input  logic [15:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_target,
  input  logic [11:0] req1_addr,
  input  logic [15:0] req1_data,
  output logic        char_wr,
  output logic        chardata_wr,
  output logic        charpal_wr,
  output logic [11:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        err,
  output logic [7:0]  budget_left
);

  localparam int unsigned    CntW       = 16;
  localparam logic [CntW-1:0] Budget    = CntW'(WR_BUDGET);
  localparam logic [7:0]     BudgetInit = (WR_BUDGET == 0 || WR_BUDGET > 255) ? 8'hFF :
                                          8'(WR_BUDGET);

  typedef enum logic [1:0] {StWait, StOpen, StExhaust} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            last_grant_q;
  logic            window, open, grant1, accept, illegal;
  logic [1:0]      sel_target;
  logic [11:0]     sel_addr;
  logic [15:0]     sel_data;
  logic [31:0]     remaining;
  logic [7:0]      budget_left_d;

  assign window = vblank | ~VBLANK_ONLY;
  assign open   = (state_q == StOpen) & window & ~frame_start;

  // With no requester valid the turn stays with whoever did not win last.
  always_comb begin
    grant1 = ~last_grant_q;
    if (req0_valid && !req1_valid) begin
      grant1 = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant1 = 1'b1;
    end
  end

  assign req0_ready = open & ~grant1;
  assign req1_ready = open & grant1;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign sel_target = grant1 ? req1_target : req0_target;
  assign sel_addr   = grant1 ? req1_addr   : req0_addr;
  assign sel_data   = grant1 ? req1_data   : req0_data;
  // charpal_ram only has 1024 words.
  assign illegal    = (sel_target == 2'b11) |
                      ((sel_target == 2'b10) & (sel_addr[11:10] != 2'b00));

  always_comb begin
    count_d = count_q;
    if (frame_start) begin
      count_d = '0;
    end else if (accept && count_q != '1) begin
      count_d = count_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = StWait;
    end else begin
      unique case (state_q)
        StWait: begin
          if (window) state_d = StOpen;
        end
        StOpen: begin
          if (WR_BUDGET != 0 && accept && count_d == Budget) begin
            state_d = StExhaust;
          end else if (!window) begin
            state_d = StWait;
          end
        end
        StExhaust: state_d = StExhaust;
        default:   state_d = StWait;
      endcase
    end
  end

  always_comb begin
    remaining     = WR_BUDGET - 32'(count_d);
    budget_left_d = 8'hFF;
    if (WR_BUDGET != 0 && remaining < 32'd255) begin
      budget_left_d = remaining[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StWait;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      char_wr      <= 1'b0;
      chardata_wr  <= 1'b0;
      charpal_wr   <= 1'b0;
      err          <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      budget_left  <= BudgetInit;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      budget_left <= budget_left_d;
      char_wr     <= accept & ~illegal & (sel_target == 2'b00);
      chardata_wr <= accept & ~illegal & (sel_target == 2'b01);
      charpal_wr  <= accept & ~illegal & (sel_target == 2'b10);
      err         <= accept & illegal;
      if (accept) begin
        last_grant_q <= grant1;
        wr_addr      <= sel_addr;
        wr_data      <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench: two arbiter configurations share one stimulus stream; a cycle-level
// reference model predicts ready, accepted writes and remaining budget for each.
module tb_vram_write_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        frame_start = 1'b0, vblank = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0]  req0_target = '0, req1_target = '0;
  logic [11:0] req0_addr = '0, req1_addr = '0;
  logic [15:0] req0_data = '0, req1_data = '0;

  logic [1:0]  rdy0, rdy1, s_char, s_cdat, s_pal, err_o;
  logic [11:0] o_addr [2];
  logic [15:0] o_data [2];
  logic [7:0]  o_bl   [2];

  vram_write_arbiter #(.VBLANK_ONLY(1'b1), .WR_BUDGET(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .vblank(vblank),
    .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_target(req0_target),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_target(req1_target),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .char_wr(s_char[0]), .chardata_wr(s_cdat[0]), .charpal_wr(s_pal[0]),
    .wr_addr(o_addr[0]), .wr_data(o_data[0]), .err(err_o[0]), .budget_left(o_bl[0])
  );

  vram_write_arbiter #(.VBLANK_ONLY(1'b0), .WR_BUDGET(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .vblank(vblank),
    .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_target(req0_target),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_target(req1_target),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .char_wr(s_char[1]), .chardata_wr(s_cdat[1]), .charpal_wr(s_pal[1]),
    .wr_addr(o_addr[1]), .wr_data(o_data[1]), .err(err_o[1]), .budget_left(o_bl[1])
  );

  typedef struct {
    int          due;
    logic [2:0]  strb;  // {charpal, chardata, char}
    logic        err;
    logic [11:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t q0[$], q1[$];
  int   checks = 0, failures = 0, cyc = 0;

  // Reference model: window/exhaust flags, accepted-write count, previous winner.
  bit m_open[2], m_exh[2], m_last[2];
  int m_cnt[2];

  function automatic bit cfg_vb(int i);
    return i == 0;
  endfunction

  function automatic int cfg_bud(int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic int exp_bl(int i);
    int r;
    if (cfg_bud(i) == 0) return 255;
    r = cfg_bud(i) - m_cnt[i];
    return (r > 255) ? 255 : r;
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=0x%0h required=0x%0h",
               name, inst, cyc, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_open[i] = 1'b0; m_exh[i] = 1'b0; m_cnt[i] = 0; m_last[i] = 1'b1;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit          win, rdy, g1, acc, bad;
        logic [1:0]  t;
        logic [11:0] a;
        exp_t        e;
        win = vblank || !cfg_vb(i);
        rdy = m_open[i] && win && !frame_start;
        if (req0_valid && !req1_valid)      g1 = 1'b0;
        else if (req1_valid && !req0_valid) g1 = 1'b1;
        else                                g1 = !m_last[i];
        if (req0_valid || req1_valid) begin
          chk("req0_ready", i, 32'(rdy0[i]), 32'(rdy && !g1));
          chk("req1_ready", i, 32'(rdy1[i]), 32'(rdy && g1));
        end else begin
          chk("ready_idle", i, 32'(rdy0[i] | rdy1[i]), 32'(rdy));
        end
        chk("budget_left", i, 32'(o_bl[i]), 32'(exp_bl(i)));
        acc = rdy && (g1 ? req1_valid : req0_valid);
        if (acc) begin
          t      = g1 ? req1_target : req0_target;
          a      = g1 ? req1_addr : req0_addr;
          bad    = (t == 2'd3) || (t == 2'd2 && a >= 12'h400);
          e.due  = cyc + 1;
          e.err  = bad;
          e.strb = bad ? 3'b000 : 3'(3'b001 << t);
          e.addr = a;
          e.data = g1 ? req1_data : req0_data;
          if (i == 0) q0.push_back(e); else q1.push_back(e);
          m_cnt[i]++;
          m_last[i] = g1;
        end
        if (frame_start) begin
          m_open[i] = 1'b0; m_exh[i] = 1'b0; m_cnt[i] = 0;
        end else if (!m_exh[i]) begin
          if (m_open[i]) begin
            if (acc && cfg_bud(i) != 0 && m_cnt[i] == cfg_bud(i)) begin
              m_open[i] = 1'b0; m_exh[i] = 1'b1;
            end else if (!win) begin
              m_open[i] = 1'b0;
            end
          end else if (win) begin
            m_open[i] = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: consumes expected writes whenever a strobe or err shows up.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [2:0] s;
      int         qn;
      exp_t       e;
      s  = {s_pal[i], s_cdat[i], s_char[i]};
      qn = (i == 0) ? q0.size() : q1.size();
      if (!rst_n) begin
        chk("reset_quiet", i, 32'({s, err_o[i], rdy0[i], rdy1[i]}), 32'd0);
      end else if (s != 3'b000 || err_o[i]) begin
        if (qn == 0) begin
          chk("spurious_write", i, 32'({s, err_o[i]}), 32'd0);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk("write_cycle", i, 32'(cyc), 32'(e.due));
          chk("strobes", i, 32'(s), 32'(e.strb));
          chk("err", i, 32'(err_o[i]), 32'(e.err));
          if (e.strb != 3'b000) begin
            chk("wr_addr", i, 32'(o_addr[i]), 32'(e.addr));
            chk("wr_data", i, 32'(o_data[i]), 32'(e.data));
          end
        end
      end else if (qn != 0) begin
        e = (i == 0) ? q0[0] : q1[0];
        if (e.due <= cyc) begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk("missing_write", i, 32'({s, err_o[i]}), 32'({e.strb, e.err}));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int r, input bit v, input logic [1:0] t, input logic [11:0] a,
                         input logic [15:0] d);
    if (r == 0) begin
      req0_valid = v; req0_target = t; req0_addr = a; req0_data = d;
    end else begin
      req1_valid = v; req1_target = t; req1_addr = a; req1_data = d;
    end
  endtask

  // Returns just after the clock edge on which instance 0 accepts req0.
  task automatic wait_accept0();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdy0[0] && req0_valid) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("accept_timeout", 0, 32'(ok), 32'd1);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  function automatic logic [11:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 12'h3FE + 12'($urandom_range(0, 3));
    return 12'($urandom);
  endfunction

  initial begin
    step(3);
    rst_n = 1'b1;
    step(2);

    // Window closed: instance 0 must stay silent, instance 1 writes freely.
    vblank = 1'b0;
    set_req(0, 1'b1, 2'd0, 12'h123, 16'h0041);
    step(100);

    vblank = 1'b1;
    wait_accept0();
    chk("single_char_wr", 0, 32'(s_char[0]), 32'd1);
    chk("single_addr", 0, 32'(o_addr[0]), 32'h123);
    chk("single_data", 0, 32'(o_data[0]), 32'h0041);
    set_req(0, 1'b0, 2'd0, 12'h0, 16'h0);
    step(1);
    chk("single_char_off", 0, 32'(s_char[0]), 32'd0);

    // Contention: alternation, then budget exhaustion on instance 0.
    pulse_frame();
    set_req(0, 1'b1, 2'd1, 12'h0AA, 16'h1111);
    set_req(1, 1'b1, 2'd0, 12'h055, 16'h2222);
    step(12);
    pulse_frame();
    set_req(0, 1'b0, 2'd0, 12'h0, 16'h0);
    step(10);

    // Illegal targets still consume budget.
    pulse_frame();
    set_req(0, 1'b1, 2'd2, 12'h400, 16'h3333);
    set_req(1, 1'b1, 2'd3, 12'h010, 16'h4444);
    step(3);
    set_req(1, 1'b1, 2'd2, 12'h3FF, 16'h5555);
    step(4);

    // frame_start arriving while open blocks that cycle.
    pulse_frame();
    step(2);
    pulse_frame();
    step(3);

    for (int k = 0; k < 600; k++) begin
      int ph;
      ph          = k % 48;
      frame_start = (ph == 0);
      vblank      = (ph >= 30) ? 1'b1 : ($urandom_range(0, 15) == 0);
      if (!req0_valid || $urandom_range(0, 3) == 0)
        set_req(0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), pick_addr(),
                16'($urandom));
      if (!req1_valid || $urandom_range(0, 3) == 0)
        set_req(1, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), pick_addr(),
                16'($urandom));
      step(1);
    end
    frame_start = 1'b0;

    // Reset while a write strobe is pending.
    vblank = 1'b1;
    set_req(1, 1'b0, 2'd0, 12'h0, 16'h0);
    set_req(0, 1'b1, 2'd0, 12'h055, 16'hBEEF);
    pulse_frame();
    wait_accept0();
    chk("pre_reset_strobe", 0, 32'(s_char[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_clear", 0, 32'(s_char[0]), 32'd0);
    chk("async_clear", 1, 32'(s_char[1]), 32'd0);
    step(2);
    rst_n = 1'b1;
    set_req(0, 1'b0, 2'd0, 12'h0, 16'h0);
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
